// File: rtl/rv32imf_dmem_obi_bridge.sv
// OBI slave terminating the LSU data port on a single-port, word-wide data SRAM.
// Define RV32IMF_DMEM_ERR_EN to answer unmapped and atomic accesses with an error response.
module rv32imf_dmem_obi_bridge #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned ADDR_W      = 14,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              obi_req_i,
   output logic              obi_gnt_o,
   input  logic [31:0]       obi_addr_i,
   input  logic              obi_we_i,
   input  logic [3:0]        obi_be_i,
   input  logic [31:0]       obi_wdata_i,
   input  logic [5:0]        obi_atop_i,
   output logic              obi_rvalid_o,
   output logic [31:0]       obi_rdata_o,
   output logic              obi_err_o,
   output logic              mem_en_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic              busy_o
);

   logic err_acc;
   logic acc;

`ifdef RV32IMF_DMEM_ERR_EN
   // End of the mapped window, kept 33 bits wide so a window touching 4 GiB cannot wrap.
   localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + (33'd1 << (ADDR_W + 2));

   assign err_acc = (obi_atop_i != 6'd0) ||
                    (obi_addr_i < BASE_ADDR) ||
                    ({1'b0, obi_addr_i} >= END_ADDR);
`else
   logic unused_addr_atop;

   assign err_acc          = 1'b0;
   assign unused_addr_atop = ^{obi_atop_i, obi_addr_i[31:ADDR_W+2], obi_addr_i[1:0]};
`endif

   // Error accesses are granted at once and never reach the SRAM.
   assign mem_en_o    = obi_req_i && !err_acc;
   assign obi_gnt_o   = obi_req_i && (err_acc || mem_gnt_i);
   assign acc         = obi_req_i && obi_gnt_o;

   assign mem_we_o    = mem_en_o && obi_we_i;
   assign mem_be_o    = mem_en_o ? obi_be_i : 4'd0;
   assign mem_addr_o  = mem_en_o ? obi_addr_i[ADDR_W+1:2] : ADDR_W'(0);
   assign mem_wdata_o = mem_en_o ? obi_wdata_i : 32'd0;

   logic [MEM_LATENCY-1:0] vld_q;
   logic [MEM_LATENCY-1:0] we_q;
   logic [MEM_LATENCY-1:0] err_q;

   // Fixed-latency response shift register; stage 0 loads the accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         we_q  <= '0;
         err_q <= '0;
      end else begin
         vld_q <= MEM_LATENCY'({vld_q, acc});
         we_q  <= MEM_LATENCY'({we_q, obi_we_i});
         err_q <= MEM_LATENCY'({err_q, err_acc});
      end
   end

   assign obi_rvalid_o = vld_q[MEM_LATENCY-1];
   assign obi_err_o    = vld_q[MEM_LATENCY-1] && err_q[MEM_LATENCY-1];
   assign obi_rdata_o  = (vld_q[MEM_LATENCY-1] && !we_q[MEM_LATENCY-1] && !err_q[MEM_LATENCY-1])
                         ? mem_rdata_i : 32'd0;
   assign busy_o       = |vld_q;

endmodule
